// File: rtl/image_pkg.sv
// image_pkg -- definitions shared by the image transmitter and the sink model.
//   Holds the field widths, the transmitter state encoding, the colour codes
//   reported by the sink and the default image geometry.
package image_pkg;

   localparam int PIX_PER_IMG_DEF = 16384;
   localparam int N_IMG_DEF       = 32;
   localparam int TIMEOUT_DEF     = 1048575;

   localparam int IMG_W   = 5;
   localparam int PIX_W   = 14;
   localparam int WAIT_W  = 20;
   localparam int PIXEL_W = 24;
   localparam int ADDR_W  = IMG_W + PIX_W;
   localparam int RES_W   = 2 + IMG_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRIME,
      ST_STREAM,
      ST_WAIT_HI,
      ST_WAIT_LO,
      ST_COLLECT,
      ST_DONE
   } tx_state_t;

   typedef enum logic [1:0] {
      COL_R = 2'd0,
      COL_G = 2'd1,
      COL_B = 2'd2
   } color_t;

   // Result entry layout: {colour, image index}.
   function automatic logic [RES_W-1:0] pack_result(input logic [1:0] color,
                                                    input logic [IMG_W-1:0] img);
      return {color, img};
   endfunction

endpackage

// File: rtl/result_buf.sv
// result_buf -- 32 x 7 result store for the image transmitter.
//   clk      : write clock
//   wr_en    : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  : write entry
//   wr_data  : {colour, image index}
//   rd_addr  : read entry
//   rd_data  : combinational read of entry rd_addr
// No reset: contents are meaningless until the first collection phase.
module result_buf
   import image_pkg::*;
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IMG_W-1:0] wr_addr,
   input  logic [RES_W-1:0] wr_data,
   input  logic [IMG_W-1:0] rd_addr,
   output logic [RES_W-1:0] rd_data
);

   logic [RES_W-1:0] mem_q [2**IMG_W];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/image_stream_tx.sv
// image_stream_tx -- streams N_IMG images of PIX_PER_IMG pixels from a pixel
// memory to a colour-classifying sink, then collects one result per image.
//   clk, reset        : clock, asynchronous active-low reset
//   start             : run request (IDLE only)
//   mem_rd, mem_addr  : pixel memory read, address {image, pixel}
//   mem_data          : pixel data, one cycle after mem_rd
//   image_in_index    : image being streamed
//   pixel_in          : streamed pixel, qualified by pixel_valid
//   busy              : sink busy
//   out_valid, color_index, image_out_index : sink result
//   res_addr, res_data: result buffer read port
//   done              : one-cycle end-of-run pulse
//   proto_err         : sticky sink protocol error, cleared by start
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_PRIME   | read of pixel 0 of the current image
// ST_STREAM  | reads continue; pixels presented two cycles after address
// ST_WAIT_HI | image sent, waiting for the sink to raise busy
// ST_WAIT_LO | waiting for the sink to drop busy before the next image
// ST_COLLECT | storing sink results until N_IMG have arrived
// ST_DONE    | done pulse, then back to idle
module image_stream_tx
   import image_pkg::*;
#(
   parameter int PIX_PER_IMG = PIX_PER_IMG_DEF,
   parameter int N_IMG       = N_IMG_DEF,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               mem_rd,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [PIXEL_W-1:0] mem_data,
   output logic [IMG_W-1:0]   image_in_index,
   output logic [PIXEL_W-1:0] pixel_in,
   output logic               pixel_valid,
   input  logic               busy,
   input  logic               out_valid,
   input  logic [1:0]         color_index,
   input  logic [IMG_W-1:0]   image_out_index,
   input  logic [IMG_W-1:0]   res_addr,
   output logic [RES_W-1:0]   res_data,
   output logic               done,
   output logic               proto_err
);

   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIX_PER_IMG - 1);
   localparam logic [IMG_W-1:0]  IMG_LAST  = IMG_W'(N_IMG - 1);
   localparam logic [IMG_W:0]    CNT_END   = (IMG_W + 1)'(N_IMG);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   tx_state_t           state_q, state_d;
   logic [IMG_W-1:0]    img_q, img_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic [IMG_W:0]      cnt_q, cnt_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                mem_rd_q, mem_rd_d;
   logic                rd_d1_q, rd_d1_d;
   logic                pix_valid_q, pix_valid_d;
   logic [PIXEL_W-1:0]  pixel_in_q, pixel_in_d;
   logic                proto_err_q, proto_err_d;
   logic                done_q, done_d;

   logic                res_we;
   logic [IMG_W:0]      cnt_inc;
   logic [WAIT_W-1:0]   wait_inc;
   logic                wait_expired;

   assign cnt_inc      = cnt_q + (IMG_W + 1)'(1);
   assign wait_inc     = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
   assign wait_expired = (wait_q == WAIT_LAST);

   always_comb begin
      state_d     = state_q;
      img_d       = img_q;
      pix_d       = pix_q;
      cnt_d       = cnt_q;
      wait_d      = wait_q;
      mem_rd_d    = 1'b0;
      rd_d1_d     = mem_rd_q;
      pix_valid_d = rd_d1_q;
      pixel_in_d  = rd_d1_q ? mem_data : pixel_in_q;
      proto_err_d = proto_err_q;
      res_we      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_PRIME;
               img_d       = '0;
               pix_d       = '0;
               cnt_d       = '0;
               proto_err_d = 1'b0;
               mem_rd_d    = 1'b1;
            end
         end

         ST_PRIME, ST_STREAM: begin
            if (mem_rd_q && (pix_q != PIX_LAST)) begin
               mem_rd_d = 1'b1;
               pix_d    = pix_q + PIX_W'(1);
            end
            if (state_q == ST_PRIME) begin
               state_d = ST_STREAM;
            end else begin
               if (busy) begin
                  proto_err_d = 1'b1;
               end
               // Last pixel is on the output and nothing is left in flight.
               if (pix_valid_q && !rd_d1_q) begin
                  state_d = ST_WAIT_HI;
                  wait_d  = '0;
               end
            end
         end

         ST_WAIT_HI: begin
            if (busy) begin
               state_d = (img_q == IMG_LAST) ? ST_COLLECT : ST_WAIT_LO;
               cnt_d   = '0;
               wait_d  = '0;
            end else if (wait_expired) begin
               state_d     = ST_DONE;
               proto_err_d = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end

         ST_WAIT_LO: begin
            if (!busy) begin
               state_d  = ST_PRIME;
               img_d    = img_q + IMG_W'(1);
               pix_d    = '0;
               mem_rd_d = 1'b1;
            end else if (wait_expired) begin
               state_d     = ST_DONE;
               proto_err_d = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end

         ST_COLLECT: begin
            if (out_valid) begin
               res_we = 1'b1;
               cnt_d  = cnt_inc;
               if (cnt_inc == CNT_END) begin
                  state_d = ST_DONE;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         img_q       <= '0;
         pix_q       <= '0;
         cnt_q       <= '0;
         wait_q      <= '0;
         mem_rd_q    <= 1'b0;
         rd_d1_q     <= 1'b0;
         pix_valid_q <= 1'b0;
         pixel_in_q  <= '0;
         proto_err_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         img_q       <= img_d;
         pix_q       <= pix_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         mem_rd_q    <= mem_rd_d;
         rd_d1_q     <= rd_d1_d;
         pix_valid_q <= pix_valid_d;
         pixel_in_q  <= pixel_in_d;
         proto_err_q <= proto_err_d;
         done_q      <= done_d;
      end
   end

   result_buf u_result_buf (
      .clk     (clk),
      .wr_en   (res_we),
      .wr_addr (cnt_q[IMG_W-1:0]),
      .wr_data (pack_result(color_index, image_out_index)),
      .rd_addr (res_addr),
      .rd_data (res_data)
   );

   assign mem_rd         = mem_rd_q;
   assign mem_addr       = {img_q, pix_q};
   assign image_in_index = img_q;
   assign pixel_in       = pixel_in_q;
   assign pixel_valid    = pix_valid_q;
   assign done           = done_q;
   assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_image_stream_tx.sv
// tb_image_stream_tx -- directed run sequence with randomized pixel data,
// sink busy durations and results for image_stream_tx.
module tb_image_stream_tx;
   import image_pkg::*;

   localparam int PIX  = 128;
   localparam int NIMG = 32;
   localparam int TO   = 128;

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic                mem_rd;
   logic [ADDR_W-1:0]   mem_addr;
   logic [PIXEL_W-1:0]  mem_data;
   logic [IMG_W-1:0]    image_in_index;
   logic [PIXEL_W-1:0]  pixel_in;
   logic                pixel_valid;
   logic                busy;
   logic                out_valid;
   logic [1:0]          color_index;
   logic [IMG_W-1:0]    image_out_index;
   logic [IMG_W-1:0]    res_addr;
   logic [RES_W-1:0]    res_data;
   logic                done;
   logic                proto_err;

   int                  checks = 0;
   int                  errors = 0;
   logic [23:0]         seed;
   logic [RES_W-1:0]    exp_res [NIMG];

   image_stream_tx #(
      .PIX_PER_IMG (PIX),
      .N_IMG       (NIMG),
      .TIMEOUT     (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .mem_rd          (mem_rd),
      .mem_addr        (mem_addr),
      .mem_data        (mem_data),
      .image_in_index  (image_in_index),
      .pixel_in        (pixel_in),
      .pixel_valid     (pixel_valid),
      .busy            (busy),
      .out_valid       (out_valid),
      .color_index     (color_index),
      .image_out_index (image_out_index),
      .res_addr        (res_addr),
      .res_data        (res_data),
      .done            (done),
      .proto_err       (proto_err)
   );

   always #5 clk = ~clk;

   // Pixel content as a function of the address.
   function automatic logic [23:0] pix_fn(input logic [18:0] a);
      logic [23:0] t;
      t = {5'b0, a} * 24'd40503;
      return t ^ {a[4:0], a} ^ seed;
   endfunction

   // One-cycle-latency memory; garbage whenever no read was issued.
   always @(posedge clk) begin
      mem_data <= (mem_rd === 1'b1) ? pix_fn(mem_addr) : 24'($urandom);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_rd"},      32'(mem_rd), 0);
      check({tag, "_mem_addr"},    32'(mem_addr), 0);
      check({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
      check({tag, "_pixel_in"},    32'(pixel_in), 0);
      check({tag, "_img_index"},   32'(image_in_index), 0);
      check({tag, "_done"},        32'(done), 0);
      check({tag, "_proto_err"},   32'(proto_err), 0);
   endtask

   // Follows one image from its first read to one cycle after its last pixel.
   // Returns at the negedge after the last pixel (or right after an abort).
   task automatic stream_image(input int img, input int busy_at, input int start_at,
                               input int rst_at);
      int               waited;
      logic [IMG_W-1:0] iw;
      iw = img[IMG_W-1:0];
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (mem_rd !== 1'b1 && waited < 300);
      check($sformatf("img%0d_prime_delay", img), 32'(waited), 1);
      if (mem_rd !== 1'b1) return;
      for (int j = 0; j <= PIX + 2; j++) begin
         if (j > 0) @(negedge clk);
         start = (j == start_at);
         if (j == 0 && img == 0) check("start_clears_proto_err", 32'(proto_err), 0);
         check($sformatf("img%0d_c%0d_mem_rd", img, j), 32'(mem_rd), 32'(j < PIX));
         if (j < PIX)
            check($sformatf("img%0d_c%0d_mem_addr", img, j), 32'(mem_addr), 32'({iw, 14'(j)}));
         check($sformatf("img%0d_c%0d_valid", img, j), 32'(pixel_valid),
               32'(j >= 2 && j <= PIX + 1));
         if (j >= 2 && j <= PIX + 1) begin
            check($sformatf("img%0d_p%0d_pixel", img, j - 2), 32'(pixel_in),
                  32'(pix_fn({iw, 14'(j - 2)})));
            check($sformatf("img%0d_p%0d_index", img, j - 2), 32'(image_in_index), 32'(iw));
         end
         if (rst_at >= 0 && j - 2 == rst_at) begin
            #2 reset = 1'b0;
            #1 check_reset_outputs("async_reset");
            return;
         end
         if (busy_at >= 0 && j - 2 == busy_at) busy = 1'b1;
      end
   endtask

   initial begin
      int     hold;
      int     gap;
      int     found;
      color_t col;

      seed            = 24'($urandom);
      reset           = 1'b1;
      start           = 1'b0;
      busy            = 1'b0;
      out_valid       = 1'b0;
      color_index     = 2'd0;
      image_out_index = '0;
      res_addr        = '0;
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Full run; a stray start during image 2 must be ignored.
      start = 1'b1;
      for (int i = 0; i < NIMG; i++) begin
         stream_image(i, -1, (i == 2) ? 10 : -1, -1);
         busy = 1'b1;
         if (i < NIMG - 1) begin
            hold = (i == 1) ? 100 : int'($urandom_range(40, 3));
            repeat (hold) @(negedge clk);
            busy = 1'b0;
         end
      end
      for (int r = 0; r < NIMG; r++) begin
         gap = int'($urandom_range(2, 0));
         for (int g = 0; g <= gap; g++) begin
            @(negedge clk);
            check($sformatf("collect_r%0d_no_done", r), 32'(done), 0);
            out_valid = (g == gap);
         end
         col             = color_t'(2'($urandom_range(2, 0)));
         color_index     = col;
         image_out_index = 5'(NIMG - 1 - r);
         exp_res[r]      = {col, 5'(NIMG - 1 - r)};
      end
      @(negedge clk);
      check("run_done_pulse", 32'(done), 1);
      check("run_proto_err", 32'(proto_err), 0);
      out_valid       = 1'b1;
      color_index     = 2'd3;
      image_out_index = 5'h1f;
      @(negedge clk);
      check("run_done_single", 32'(done), 0);
      busy = 1'b0;
      repeat (3) @(negedge clk);
      out_valid = 1'b0;
      for (int r = 0; r < NIMG; r++) begin
         res_addr = 5'(r);
         #1 check($sformatf("res_data_%0d", r), 32'(res_data), 32'(exp_res[r]));
      end
      @(negedge clk);

      // Sink never raises busy: timeout ends the run with an error.
      start = 1'b1;
      stream_image(0, -1, -1, -1);
      found = 0;
      for (int k = 1; k <= TO + 10 && found == 0; k++) begin
         if (k > 1) @(negedge clk);
         if (done === 1'b1) found = k;
      end
      check("timeout_done_delay", 32'(found), 32'(TO + 1));
      check("timeout_proto_err", 32'(proto_err), 1);
      @(negedge clk);
      check("timeout_done_single", 32'(done), 0);
      for (int r = 0; r < NIMG; r++) begin
         res_addr = 5'(r);
         #1 check($sformatf("res_hold_%0d", r), 32'(res_data), 32'(exp_res[r]));
      end
      @(negedge clk);

      // Busy during streaming, then a reset in the middle of image 3.
      start = 1'b1;
      stream_image(0, 100, -1, -1);
      check("stream_busy_proto_err", 32'(proto_err), 1);
      repeat (10) @(negedge clk);
      busy = 1'b0;
      for (int i = 1; i < 3; i++) begin
         stream_image(i, -1, -1, -1);
         busy = 1'b1;
         repeat (20) @(negedge clk);
         busy = 1'b0;
      end
      stream_image(3, -1, -1, 50);
      busy = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("in_reset_mem_rd", 32'(mem_rd), 0);
         check("in_reset_valid", 32'(pixel_valid), 0);
      end
      reset = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("after_reset_mem_rd", 32'(mem_rd), 0);
         check("after_reset_valid", 32'(pixel_valid), 0);
      end
      start = 1'b1;
      stream_image(0, -1, -1, -1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
